// File: rtl/wrr_burst_sched_pkg.sv
// Shared types and helpers for the weighted round-robin burst scheduler.
// Default geometry comes from NUM_REQS / ARB_QWID macros when the build does not supply them.
`ifndef NUM_REQS
`define NUM_REQS 4
`endif
`ifndef ARB_QWID
`define ARB_QWID 4
`endif

package wrr_pkg;

  typedef enum logic {IDLE, SERVE} wrr_state_t;

  // Upper bounds for the generic weight-slice helper.
  localparam int WMAX = 1024;
  localparam int QMAX = 32;

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [QMAX-1:0] weight_at(input logic [WMAX-1:0] w,
                                                input int unsigned i,
                                                input int unsigned qw);
    return QMAX'(w >> (i * qw));
  endfunction

endpackage

// File: rtl/wrr_burst_sched_rr_pick.sv
// Combinational rotating-priority encoder: first set bit of elig at or after ptr,
// wrapping from NUM_REQS-1 back to 0.
module rr_pick
  import wrr_pkg::*;
#(
  parameter int NUM_REQS = 4,
  localparam int IDXW = idx_w(NUM_REQS)
)(
  input  logic [NUM_REQS-1:0] elig,
  input  logic [IDXW-1:0]     ptr,
  output logic                found,
  output logic [IDXW-1:0]     idx
);

  function automatic logic [IDXW-1:0] wrap_add(input logic [IDXW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NUM_REQS) s = s - NUM_REQS;
    return IDXW'(s);
  endfunction

  // Scan from farthest to nearest so the nearest eligible requester wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      if (elig[wrap_add(ptr, k)]) begin
        found = 1'b1;
        idx   = wrap_add(ptr, k);
      end
    end
  end

endmodule

// File: rtl/wrr_burst_sched.sv
// Weighted round-robin burst scheduler sharing one pop port among NUM_REQS FIFOs.
// Define WRR_SVA_EN to compile in the concurrent assertions and the formal weight assumption.
module wrr_burst_sched
  import wrr_pkg::*;
#(
  parameter int NUM_REQS = `NUM_REQS,
  parameter int QWID     = `ARB_QWID,
  localparam int IDXW    = idx_w(NUM_REQS)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQS-1:0]      reqs,
  input  logic [NUM_REQS*QWID-1:0] weights,
  input  logic                     out_rdy,
  output logic [NUM_REQS-1:0]      gnt,
  output logic [IDXW-1:0]          owner,
  output logic                     busy
);

  wrr_state_t      state, state_d;
  logic [IDXW-1:0] ptr, ptr_d;
  logic [IDXW-1:0] cur, cur_d;
  logic [QWID-1:0] cnt, cnt_d;

  logic [WMAX-1:0]     weights_ext;
  logic [QWID-1:0]     wt [NUM_REQS];
  logic [NUM_REQS-1:0] elig;
  logic                pick_found;
  logic [IDXW-1:0]     pick_idx;
  logic [NUM_REQS-1:0] gnt_raw;
  logic [IDXW-1:0]     cur_next;

  assign weights_ext = WMAX'(weights);

  always_comb begin
    for (int i = 0; i < NUM_REQS; i++) begin
      wt[i]   = QWID'(weight_at(weights_ext, i, QWID));
      elig[i] = reqs[i] && (wt[i] != '0);
    end
  end

  rr_pick #(.NUM_REQS(NUM_REQS)) u_pick (
    .elig  (elig),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign cur_next = (cur == IDXW'(NUM_REQS - 1)) ? '0 : cur + 1'b1;

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cur_d   = cur;
    cnt_d   = cnt;
    gnt_raw = '0;
    unique case (state)
      IDLE: begin
        if (pick_found) begin
          cur_d   = pick_idx;
          cnt_d   = wt[pick_idx];
          state_d = SERVE;
        end
      end
      SERVE: begin
        // A drained owner gives up the port immediately, without a beat.
        if (!reqs[cur]) begin
          state_d = IDLE;
          ptr_d   = cur_next;
        end else if (out_rdy) begin
          gnt_raw[cur] = 1'b1;
          if (cnt == QWID'(1)) begin
            state_d = IDLE;
            ptr_d   = cur_next;
          end else begin
            cnt_d = cnt - 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr   <= '0;
      cur   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      ptr   <= ptr_d;
      cur   <= cur_d;
      cnt   <= cnt_d;
    end
  end

  // Reset masks the combinational outputs in the reset cycle itself.
  assign busy  = (state == SERVE) && !rst;
  assign gnt   = rst ? '0 : gnt_raw;
  assign owner = busy ? cur : '0;

`ifdef WRR_SVA_EN
  logic [QWID-1:0] sva_wt;

  always_ff @(posedge clk) begin
    if (rst) sva_wt <= '0;
    else if (state == IDLE && pick_found) sva_wt <= wt[pick_idx];
  end

  a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
  a_cnt:    assert property (@(posedge clk) disable iff (rst) busy |-> (cnt != '0));
  a_wt:     assert property (@(posedge clk) disable iff (rst) (gnt != '0) |-> (sva_wt != '0));
  m_wt:     assume property (@(posedge clk) disable iff (rst) $stable(weights));

  for (genvar g = 0; g < NUM_REQS; g++) begin : g_sva
    a_gnt: assert property (@(posedge clk) disable iff (rst)
                            gnt[g] |-> (reqs[g] && out_rdy && busy));
  end
`endif

endmodule

// File: tb/tb_wrr_burst_sched.sv
// Self-checking bench for wrr_burst_sched: directed scenarios plus randomized traffic
// compared against a burst-level reference model.
module tb_wrr_burst_sched;
  localparam int N  = 4;
  localparam int Q  = 4;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   reqs;
  logic [N*Q-1:0] weights;
  logic           out_rdy;
  logic [N-1:0]   gnt;
  logic [IW-1:0]  owner;
  logic           busy;

  always #5 clk = ~clk;

  wrr_burst_sched #(.NUM_REQS(N), .QWID(Q)) dut (
    .clk     (clk),
    .rst     (rst),
    .reqs    (reqs),
    .weights (weights),
    .out_rdy (out_rdy),
    .gnt     (gnt),
    .owner   (owner),
    .busy    (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: which requester holds the port and how many beats it has left.
  bit m_serving = 0;
  int m_who = 0, m_left = 0, m_ptr = 0;
  logic [N-1:0]  exp_gnt;
  logic          exp_busy;
  logic [IW-1:0] exp_owner;

  function automatic int wv(input int i);
    logic [N*Q-1:0] s;
    s = weights >> (Q * i);
    return int'(s[Q-1:0]);
  endfunction

  task automatic tick();
    @(negedge clk);
    exp_gnt = '0; exp_busy = 1'b0; exp_owner = '0;
    if (!rst && m_serving) begin
      exp_busy  = 1'b1;
      exp_owner = IW'(m_who);
      if (reqs[m_who] && out_rdy) exp_gnt = N'(1) << m_who;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    if (rst) begin
      m_serving = 0; m_ptr = 0;
    end else if (!m_serving) begin
      for (int k = 0; k < N; k++) begin
        int j;
        j = (m_ptr + k) % N;
        if (!m_serving && reqs[j] && wv(j) != 0) begin
          m_serving = 1; m_who = j; m_left = wv(j);
        end
      end
    end else if (!reqs[m_who]) begin
      m_serving = 0; m_ptr = (m_who + 1) % N;
    end else if (out_rdy) begin
      m_left--;
      if (m_left == 0) begin
        m_serving = 0; m_ptr = (m_who + 1) % N;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(); advance();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; reqs = 4'b1111; weights = 16'h1234; out_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        n_bad++; $display("FAIL reset_out cyc=%0d gnt=%b busy=%b want gnt=0000 busy=0", c, gnt, busy);
      end
      advance();
    end
    rst = 1'b0;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_bubble gnt=%b busy=%b want gnt=0000 busy=0", gnt, busy);
    end
    advance();
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      n_bad++; $display("FAIL reset_first_gnt gnt=%b busy=%b want gnt=0001 busy=1", gnt, busy);
    end
    advance();
  endtask

  task automatic test_fairness();
    logic [N-1:0] seq[$];
    weights = 16'h1234; reqs = 4'b1111; out_rdy = 1'b1;
    do_reset();
    seq.push_back('0);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++) begin
        for (int b = 0; b < wv(i); b++) seq.push_back(N'(1) << i);
        seq.push_back('0);
      end
    foreach (seq[k]) begin
      tick();
      n_cmp++;
      if (gnt !== seq[k]) begin
        n_bad++; $display("FAIL fair_seq step=%0d gnt=%b want=%b", k, gnt, seq[k]);
      end
      n_cmp++;
      if (gnt !== exp_gnt) begin
        n_bad++; $display("FAIL fair_model step=%0d gnt=%b want=%b", k, gnt, exp_gnt);
      end
      advance();
    end
  endtask

  task automatic test_zero_weight();
    int g0 = 0;
    weights = 16'h1203; reqs = 4'b0011; out_rdy = 1'b1;
    do_reset();
    for (int c = 0; c < 100; c++) begin
      tick();
      n_cmp++;
      if (gnt[1] !== 1'b0 || gnt !== exp_gnt) begin
        n_bad++; $display("FAIL zero_weight cyc=%0d gnt=%b want=%b", c, gnt, exp_gnt);
      end
      if (gnt[0]) g0++;
      advance();
    end
    n_cmp++;
    if (g0 != 75) begin
      n_bad++; $display("FAIL zero_weight_req0_beats got=%0d want=75", g0);
    end
  endtask

  task automatic test_backpressure();
    weights = 16'h1234; reqs = 4'b0001; out_rdy = 1'b1;
    do_reset();
    tick(); advance();
    for (int b = 0; b < 2; b++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0001) begin
        n_bad++; $display("FAIL bp_pre_beat b=%0d gnt=%b want=0001", b, gnt);
      end
      advance();
    end
    out_rdy = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0000 || busy !== 1'b1 || owner !== 2'd0) begin
        n_bad++; $display("FAIL bp_hold cyc=%0d gnt=%b busy=%b owner=%0d want 0000/1/0", c, gnt, busy, owner);
      end
      advance();
    end
    out_rdy = 1'b1;
    for (int b = 0; b < 2; b++) begin
      tick();
      n_cmp++;
      if (gnt !== 4'b0001) begin
        n_bad++; $display("FAIL bp_post_beat b=%0d gnt=%b want=0001", b, gnt);
      end
      advance();
    end
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL bp_release gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    advance();
  endtask

  task automatic test_early_release();
    weights = 16'h1324; reqs = 4'b0100; out_rdy = 1'b1;
    do_reset();
    tick(); advance();
    tick();
    n_cmp++;
    if (gnt !== 4'b0100 || owner !== 2'd2) begin
      n_bad++; $display("FAIL er_beat gnt=%b owner=%0d want 0100/2", gnt, owner);
    end
    advance();
    reqs = 4'b0011;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b1) begin
      n_bad++; $display("FAIL er_release gnt=%b busy=%b want 0000/1", gnt, busy);
    end
    advance();
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL er_idle gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    advance();
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      n_bad++; $display("FAIL er_wrap gnt=%b owner=%0d want 0001/0", gnt, owner);
    end
    advance();
  endtask

  task automatic test_reset_mid_burst();
    weights = 16'h4324; reqs = 4'b1000; out_rdy = 1'b1;
    do_reset();
    tick(); advance();
    tick();
    n_cmp++;
    if (gnt !== 4'b1000) begin
      n_bad++; $display("FAIL rmb_beat gnt=%b want=1000", gnt);
    end
    advance();
    rst = 1'b1; reqs = 4'b1001;
    tick();
    n_cmp++;
    if (gnt !== 4'b0000 || busy !== 1'b0) begin
      n_bad++; $display("FAIL rmb_reset_cycle gnt=%b busy=%b want 0000/0", gnt, busy);
    end
    advance();
    rst = 1'b0;
    tick(); advance();
    tick();
    n_cmp++;
    if (gnt !== 4'b0001 || owner !== 2'd0) begin
      n_bad++; $display("FAIL rmb_restart gnt=%b owner=%0d want 0001/0", gnt, owner);
    end
    advance();
  endtask

  task automatic test_random();
    weights = 16'(($urandom));
    reqs = 4'(($urandom));
    for (int c = 0; c < 1500; c++) begin
      rst     = ($urandom_range(0, 63) == 0);
      out_rdy = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) reqs = 4'($urandom);
      if ($urandom_range(0, 15) == 0) weights = 16'($urandom);
      tick();
      n_cmp++;
      if (gnt !== exp_gnt || busy !== exp_busy || (exp_busy && owner !== exp_owner)) begin
        n_bad++;
        $display("FAIL random cyc=%0d gnt=%b busy=%b owner=%0d want gnt=%b busy=%b owner=%0d",
                 c, gnt, busy, owner, exp_gnt, exp_busy, exp_owner);
      end
      advance();
    end
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; reqs = '0; weights = '0; out_rdy = 1'b0;
    test_reset();
    test_fairness();
    test_zero_weight();
    test_backpressure();
    test_early_release();
    test_reset_mid_burst();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
